delay_scheduler: RTL and testbench

DELAY_SCHEDULER -- requirements
Module: delay_scheduler

---
 rtl/delay_scheduler.sv | 125 ++++++++++++
 tb/tb_delay_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_scheduler.sv
// Round-robin arbiter that lends one shared up-counter to NREQ requesters in turn.
// Define DELAY_SCHEDULER_ABORT_EN to let an owner cancel its job by dropping req.
module delay_scheduler #(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [32*NREQ-1:0]      delay,
  input  logic [7:0]              step,
  input  logic                    ctr_done,
  output logic [31:0]             ctr_max,
  output logic                    ctr_counting,
  output logic [7:0]              ctr_incr,
  output logic [NREQ-1:0]         ack,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int GW = $clog2(NREQ);

`ifdef DELAY_SCHEDULER_ABORT_EN
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, ABORT} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE} state_t;
`endif

  state_t          state;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   win;
  logic [GW-1:0]   cand;
  logic            any;
  logic [31:0]     win_delay;

  // Scan downward so the candidate nearest last_grant+1 is the one that sticks.
  always_comb begin
    any  = 1'b0;
    win  = '0;
    cand = '0;
    for (int off = NREQ; off >= 1; off--) begin
      cand = GW'((int'(last_grant) + off) % NREQ);
      if (req[cand]) begin
        any = 1'b1;
        win = cand;
      end
    end
  end

  always_comb begin
    win_delay = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == GW'(i)) win_delay = delay[32*i +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      ctr_max      <= '0;
      ctr_counting <= 1'b0;
      ctr_incr     <= '0;
      ack          <= '0;
      busy         <= 1'b0;
      grant_id     <= '0;
      last_grant   <= GW'(NREQ - 1);
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (any) begin
            ctr_max  <= win_delay;
            ctr_incr <= step;
            grant_id <= win;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
`ifdef DELAY_SCHEDULER_ABORT_EN
          if (!req[grant_id]) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            ctr_counting <= 1'b1;
            state        <= RUN;
          end
`else
          ctr_counting <= 1'b1;
          state        <= RUN;
`endif
        end
        RUN: begin
          // Completion wins over a simultaneous req drop.
          if (ctr_done) begin
            ctr_counting <= 1'b0;
            ack          <= NREQ'(1) << grant_id;
            state        <= DONE;
          end
`ifdef DELAY_SCHEDULER_ABORT_EN
          else if (!req[grant_id]) begin
            // Max of zero with counting held forces the counter to wrap to 0.
            ctr_max <= '0;
            state   <= ABORT;
          end
`endif
        end
        DONE: begin
          last_grant <= grant_id;
          busy       <= 1'b0;
          state      <= IDLE;
        end
`ifdef DELAY_SCHEDULER_ABORT_EN
        ABORT: begin
          ctr_counting <= 1'b0;
          last_grant   <= grant_id;
          busy         <= 1'b0;
          state        <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_scheduler.sv
// Bench for delay_scheduler: models the shared counter and scores acks against expected cycles.
module tb_delay_scheduler;

  localparam int NREQ = 4;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [32*NREQ-1:0] delay;
  logic [7:0]        step;
  logic              ctr_done;
  logic [31:0]       ctr_max;
  logic              ctr_counting;
  logic [7:0]        ctr_incr;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic [1:0]        grant_id;

  delay_scheduler #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .delay(delay), .step(step),
    .ctr_done(ctr_done), .ctr_max(ctr_max), .ctr_counting(ctr_counting),
    .ctr_incr(ctr_incr), .ack(ack), .busy(busy), .grant_id(grant_id)
  );

  typedef struct { int id; int cyc; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared counter, reset from the same net (inverted sense).
  assign ctr_done = (cnt >= ctr_max);
  always @(posedge clk) begin
    if (!rst) cnt <= '0;
    else if (ctr_counting) cnt <= ctr_done ? 32'd0 : cnt + 32'd1 + {24'd0, ctr_incr};
  end

  always @(negedge clk) begin
    if (rst && ack !== '0) begin
      checks++;
      if (!$onehot(ack)) begin
        errors++;
        $display("FAIL ack_onehot: got %b want one-hot", ack);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: got ack %b at cycle %0d want no ack", name, ack, cyc);
    end else begin
      e = sb.pop_front();
      if (ack !== (4'(1) << e.id) || cyc != e.cyc || grant_id !== 2'(e.id)) begin
        errors++;
        $display("FAIL %s: got ack %b grant %0d cycle %0d want id %0d cycle %0d",
                 name, ack, grant_id, cyc, e.id, e.cyc);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (ack !== '0 || busy !== 1'b0 || grant_id !== '0 || ctr_max !== '0 ||
        ctr_counting !== 1'b0 || ctr_incr !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ack %b busy %b gid %0d max %0d cnt_en %b incr %0d want all 0",
               ack, busy, grant_id, ctr_max, ctr_counting, ctr_incr);
    end
    @(posedge clk); #1;
  endtask

  // One job end to end; optionally disturbs the owner's inputs after LOAD.
  task automatic run_job(input int id, input int d, input int s, input bit scramble, input string name);
    int k, first_cnt, n_cnt, runs;
    bit got;
    delay[32*id +: 32] = d;
    step = 8'(s);
    req[id] = 1'b1;
    k = cyc;
    runs = (d + s) / (s + 1);
    sb.push_back('{id, k + 3 + runs});
    first_cnt = -1; n_cnt = 0; got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (scramble && cyc == k + 1) begin
        delay[32*id +: 32] = 32'hFFFF;
        step = 8'hFF;
      end
      if (ctr_counting) begin
        if (first_cnt < 0) first_cnt = cyc;
        n_cnt++;
        checks++;
        if (ctr_max !== 32'(d) || ctr_incr !== 8'(s)) begin
          errors++;
          $display("FAIL %s_hold: got max %0d incr %0d want %0d %0d", name, ctr_max, ctr_incr, d, s);
        end
      end
      if (ack !== '0) begin
        got = 1'b1;
        pop_check(name);
        req[id] = 1'b0;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: got no ack want ack for id %0d", name, id);
      sb.delete();
    end
    checks++;
    if (first_cnt != k + 2 || n_cnt != runs + 1) begin
      errors++;
      $display("FAIL %s_counting: got start %0d len %0d want start %0d len %0d",
               name, first_cnt, n_cnt, k + 2, runs + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int k, n;
    do_reset();
    delay = '0;
    step = 8'd0;
    req = 4'b1111;
    k = cyc;
    for (int i = 0; i < 5; i++) sb.push_back('{i % 4, k + 3 + 4*i});
    n = 0;
    for (int i = 0; i < 100 && n < 5; i++) begin
      @(negedge clk);
      if (ack !== '0) begin
        pop_check("rr_order");
        n++;
        if (n == 5) req = '0;
      end
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL rr_timeout: got %0d acks want 5", n);
      sb.delete();
      req = '0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int k;
    bit got;
    do_reset();
    run_job(1, 2, 0, 1'b0, "pre_reset");
    delay[32*2 +: 32] = 32'd50;
    step = 8'd0;
    req = 4'b0100;
    repeat (6) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 begin rst = 1'b1; req = '0; end
    @(negedge clk);
    checks++;
    if (ack !== '0 || busy !== 1'b0 || grant_id !== '0 || ctr_max !== '0 ||
        ctr_counting !== 1'b0 || ctr_incr !== '0 || cnt !== '0) begin
      errors++;
      $display("FAIL midrun_reset: got ack %b busy %b gid %0d max %0d en %b incr %0d cnt %0d want all 0",
               ack, busy, grant_id, ctr_max, ctr_counting, ctr_incr, cnt);
    end
    @(posedge clk); #1;
    delay = '0;
    req = 4'b1111;
    k = cyc;
    sb.push_back('{0, k + 3});
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (ack !== '0) begin
        got = 1'b1;
        pop_check("restart_from_0");
        req = '0;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL restart_timeout: got no ack want id 0");
      sb.delete();
      req = '0;
    end
    @(posedge clk); #1;
  endtask

`ifdef DELAY_SCHEDULER_ABORT_EN
  task automatic test_req_drop();
    int acks;
    do_reset();
    delay[31:0] = 32'd100;
    step = 8'd0;
    req = 4'b0001;
    repeat (6) @(posedge clk);
    #1 req = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ctr_max !== '0 || ctr_counting !== 1'b1 || busy !== 1'b1 || ack !== '0) begin
      errors++;
      $display("FAIL abort_state: got max %0d en %b busy %b ack %b want 0 1 1 0",
               ctr_max, ctr_counting, busy, ack);
    end
    @(negedge clk);
    checks++;
    if (cnt !== '0 || busy !== 1'b0 || ctr_counting !== 1'b0) begin
      errors++;
      $display("FAIL abort_after: got cnt %0d busy %b en %b want 0 0 0", cnt, busy, ctr_counting);
    end
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack !== '0) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL abort_no_ack: got %0d acks want 0", acks);
    end
    @(posedge clk); #1;
  endtask
`else
  task automatic test_req_drop();
    int k;
    bit got;
    do_reset();
    delay[31:0] = 32'd10;
    step = 8'd0;
    req = 4'b0001;
    k = cyc;
    sb.push_back('{0, k + 13});
    repeat (4) @(posedge clk);
    #1 req = '0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (ack !== '0) begin
        got = 1'b1;
        pop_check("drop_ignored");
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL drop_timeout: got no ack want id 0");
      sb.delete();
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    rst = 1'b0;
    req = '0;
    delay = '0;
    step = 8'd0;
    test_reset();
    run_job(0, 3, 0, 1'b0, "basic_d3");
    run_job(1, 10, 4, 1'b0, "step4_d10");
    run_job(2, 0, 0, 1'b0, "zero_delay");
    run_job(3, 7, 2, 1'b0, "overshoot");
    run_job(0, 9, 1, 1'b1, "owner_change");
    test_round_robin();
    test_reset_mid_run();
    test_req_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
